// File: rtl/super_writeback.sv
// super_writeback: writeback stage with register-file writes, jump redirect with a fixed
// squash window, sticky end-of-program halt and a saturating retire counter.
module super_writeback #(
    parameter int REGI_BITS    = 4,
    parameter int VECT_BITS    = 2,
    parameter int VECT_SIZE    = 8,
    parameter int ELEM_SIZE    = 8,
    parameter int SQUASH_SLOTS = 2,
    localparam int DW          = VECT_SIZE * ELEM_SIZE
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DW-1:0]        int_rd_i,
    input  logic [DW-1:0]        alu_res_i,
    input  logic                 enableReg_i,
    input  logic                 enableJump_i,
    input  logic                 flagMemRead_i,
    input  logic                 flagMemWrite_i,
    input  logic                 flagEnd_i,
    input  logic                 flagNop_i,
    input  logic                 writeResultInt_i,
    input  logic                 writeResultV_i,
    input  logic [9:0]           jumpAddress_i,
    input  logic [REGI_BITS-1:0] intRegDest_i,
    input  logic [VECT_BITS-1:0] vecRegDest_i,
    output logic                 int_we_o,
    output logic [REGI_BITS-1:0] int_wa_o,
    output logic [DW-1:0]        int_wd_o,
    output logic                 vec_we_o,
    output logic [VECT_BITS-1:0] vec_wa_o,
    output logic [DW-1:0]        vec_wd_o,
    output logic                 pc_load_o,
    output logic [9:0]           pc_addr_o,
    output logic                 flush_o,
    output logic                 halt_o,
    output logic [15:0]          retired_o
);
    typedef enum logic [1:0] {RUN, SQUASH, HALT} state_t;

    state_t               r_state;
    logic [2:0]           r_cnt;
    logic                 r_int_we, r_vec_we, r_pc_load, r_flush, r_halt;
    logic [REGI_BITS-1:0] r_int_wa;
    logic [VECT_BITS-1:0] r_vec_wa;
    logic [DW-1:0]        r_int_wd, r_vec_wd;
    logic [9:0]           r_pc_addr;
    logic [15:0]          r_retired;

    logic          w_valid, w_wr, w_int_we, w_vec_we, w_jump, w_end;
    logic [DW-1:0] w_wd;

    assign w_valid  = !flagNop_i && r_state == RUN && !r_halt;
    assign w_wd     = flagMemRead_i ? int_rd_i : alu_res_i;
    // An end instruction never writes and overrides any jump on the same slot.
    assign w_wr     = w_valid && enableReg_i && !flagMemWrite_i && !flagEnd_i;
    assign w_int_we = w_wr && writeResultInt_i;
    assign w_vec_we = w_wr && writeResultV_i;
    assign w_jump   = w_valid && enableJump_i && !flagEnd_i;
    assign w_end    = w_valid && flagEnd_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= RUN;
            r_cnt     <= '0;
            r_int_we  <= 1'b0;
            r_vec_we  <= 1'b0;
            r_pc_load <= 1'b0;
            r_flush   <= 1'b0;
            r_halt    <= 1'b0;
            r_int_wa  <= '0;
            r_vec_wa  <= '0;
            r_int_wd  <= '0;
            r_vec_wd  <= '0;
            r_pc_addr <= '0;
            r_retired <= '0;
        end else begin
            r_int_we  <= w_int_we;
            r_vec_we  <= w_vec_we;
            r_pc_load <= w_jump;
            if (w_int_we) begin
                r_int_wa <= intRegDest_i;
                r_int_wd <= w_wd;
            end
            if (w_vec_we) begin
                r_vec_wa <= vecRegDest_i;
                r_vec_wd <= w_wd;
            end
            if (w_jump)
                r_pc_addr <= jumpAddress_i;
            if (w_valid && r_retired != 16'hFFFF)
                r_retired <= r_retired + 16'd1;
            case (r_state)
                RUN: begin
                    if (w_end) begin
                        r_state <= HALT;
                        r_halt  <= 1'b1;
                    end else if (w_jump) begin
                        r_state <= SQUASH;
                        r_cnt   <= 3'(SQUASH_SLOTS);
                        r_flush <= 1'b1;
                    end
                end
                SQUASH: begin
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        r_state <= RUN;
                        r_flush <= 1'b0;
                    end
                end
                default: r_state <= HALT;
            endcase
        end
    end

    assign int_we_o  = r_int_we;
    assign int_wa_o  = r_int_wa;
    assign int_wd_o  = r_int_wd;
    assign vec_we_o  = r_vec_we;
    assign vec_wa_o  = r_vec_wa;
    assign vec_wd_o  = r_vec_wd;
    assign pc_load_o = r_pc_load;
    assign pc_addr_o = r_pc_addr;
    assign flush_o   = r_flush;
    assign halt_o    = r_halt;
    assign retired_o = r_retired;
endmodule

// File: tb/tb_super_writeback.sv
// tb_super_writeback: directed slots push expected register/pc writes into queues;
// a monitor pops and compares whenever the DUT asserts a write or pc load.
module tb_super_writeback;
    localparam logic [7:0] MR = 8'h80, MW = 8'h40, EN = 8'h20, JMP = 8'h10;
    localparam logic [7:0] ENDF = 8'h08, NOP = 8'h04, WI = 8'h02, WV = 8'h01;

    logic        clk_i = 1'b0, rst_i;
    logic [63:0] int_rd_i, alu_res_i;
    logic        enableReg_i, enableJump_i, flagMemRead_i, flagMemWrite_i, flagEnd_i, flagNop_i;
    logic        writeResultInt_i, writeResultV_i;
    logic [9:0]  jumpAddress_i;
    logic [3:0]  intRegDest_i;
    logic [1:0]  vecRegDest_i;
    logic        int_we_o, vec_we_o, pc_load_o, flush_o, halt_o;
    logic [3:0]  int_wa_o;
    logic [1:0]  vec_wa_o;
    logic [63:0] int_wd_o, vec_wd_o;
    logic [9:0]  pc_addr_o;
    logic [15:0] retired_o;

    int checks = 0, failures = 0;
    logic [67:0] iq[$];
    logic [65:0] vq[$];
    logic [9:0]  pq[$];

    super_writeback dut (
        .clk_i(clk_i), .rst_i(rst_i), .int_rd_i(int_rd_i), .alu_res_i(alu_res_i),
        .enableReg_i(enableReg_i), .enableJump_i(enableJump_i), .flagMemRead_i(flagMemRead_i),
        .flagMemWrite_i(flagMemWrite_i), .flagEnd_i(flagEnd_i), .flagNop_i(flagNop_i),
        .writeResultInt_i(writeResultInt_i), .writeResultV_i(writeResultV_i),
        .jumpAddress_i(jumpAddress_i), .intRegDest_i(intRegDest_i), .vecRegDest_i(vecRegDest_i),
        .int_we_o(int_we_o), .int_wa_o(int_wa_o), .int_wd_o(int_wd_o),
        .vec_we_o(vec_we_o), .vec_wa_o(vec_wa_o), .vec_wd_o(vec_wd_o),
        .pc_load_o(pc_load_o), .pc_addr_o(pc_addr_o), .flush_o(flush_o),
        .halt_o(halt_o), .retired_o(retired_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", n, act, exp);
        end
    endtask

    task automatic slot(input logic [7:0] f, input logic [63:0] rd, input logic [63:0] alu,
                        input logic [9:0] ja, input logic [3:0] ird, input logic [1:0] vrd,
                        input bit ei, input bit ev, input bit ep);
        @(negedge clk_i);
        {flagMemRead_i, flagMemWrite_i, enableReg_i, enableJump_i,
         flagEnd_i, flagNop_i, writeResultInt_i, writeResultV_i} = f;
        int_rd_i = rd;
        alu_res_i = alu;
        jumpAddress_i = ja;
        intRegDest_i = ird;
        vecRegDest_i = vrd;
        if (ei) iq.push_back({ird, f[7] ? rd : alu});
        if (ev) vq.push_back({vrd, f[7] ? rd : alu});
        if (ep) pq.push_back(ja);
    endtask

    task automatic idle();
        slot(NOP, 64'h0, 64'h0, 10'h0, 4'h0, 2'h0, 0, 0, 0);
    endtask

    task automatic drain();
        idle();
        idle();
        chk("int_queue_left", 64'(iq.size()), 64'd0);
        chk("vec_queue_left", 64'(vq.size()), 64'd0);
        chk("pc_queue_left", 64'(pq.size()), 64'd0);
    endtask

    task automatic chk_zero(input string n);
        chk({n, "_flags"}, {59'd0, int_we_o, vec_we_o, pc_load_o, flush_o, halt_o}, 64'd0);
        chk({n, "_int_wd"}, int_wd_o, 64'd0);
        chk({n, "_vec_wd"}, vec_wd_o, 64'd0);
        chk({n, "_addrs"}, {48'd0, int_wa_o, vec_wa_o, pc_addr_o}, 64'd0);
        chk({n, "_retired"}, 64'(retired_o), 64'd0);
    endtask

    always @(posedge clk_i) begin
        logic [67:0] ie;
        logic [65:0] ve;
        #2;
        if (int_we_o) begin
            if (iq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL int_we_unexpected actual=1 expected=0 wa=%h wd=%h", int_wa_o, int_wd_o);
            end else begin
                ie = iq.pop_front();
                chk("int_wa", 64'(int_wa_o), 64'(ie[67:64]));
                chk("int_wd", int_wd_o, ie[63:0]);
            end
        end
        if (vec_we_o) begin
            if (vq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL vec_we_unexpected actual=1 expected=0 wa=%h wd=%h", vec_wa_o, vec_wd_o);
            end else begin
                ve = vq.pop_front();
                chk("vec_wa", 64'(vec_wa_o), 64'(ve[65:64]));
                chk("vec_wd", vec_wd_o, ve[63:0]);
            end
        end
        if (pc_load_o) begin
            if (pq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pc_load_unexpected actual=1 expected=0 addr=%h", pc_addr_o);
            end else
                chk("pc_addr", 64'(pc_addr_o), 64'(pq.pop_front()));
        end
    end

    initial begin
        rst_i = 1'b0;
        {flagMemRead_i, flagMemWrite_i, enableReg_i, enableJump_i,
         flagEnd_i, flagNop_i, writeResultInt_i, writeResultV_i} = NOP;
        int_rd_i = '0; alu_res_i = '0; jumpAddress_i = '0; intRegDest_i = '0; vecRegDest_i = '0;
        #7;
        chk_zero("reset");
        #5 rst_i = 1'b1;
        // load, dual ALU write, store, nop
        slot(MR | EN | WI, 64'h0123456789ABCDEF, 64'h0, 10'h0, 4'd5, 2'd0, 1, 0, 0);
        slot(EN | WI | WV, 64'h0, 64'hDEADBEEFCAFEF00D, 10'h0, 4'd3, 2'd2, 1, 1, 0);
        slot(MW | EN | WV, 64'h55, 64'h66, 10'h0, 4'd0, 2'd1, 0, 0, 0);
        idle();
        drain();
        chk("retired_after_store_nop", 64'(retired_o), 64'd3);
        // jump then three writes: two squashed, third lands
        slot(EN | WI | JMP, 64'h0, 64'h11, 10'h3A0, 4'd7, 2'd0, 1, 0, 1);
        slot(EN | WI, 64'h0, 64'h22, 10'h0, 4'd8, 2'd0, 0, 0, 0);
        chk("flush_cycle1", 64'(flush_o), 64'd1);
        slot(EN | WI, 64'h0, 64'h33, 10'h0, 4'd9, 2'd0, 0, 0, 0);
        chk("flush_cycle2", 64'(flush_o), 64'd1);
        slot(EN | WI, 64'h0, 64'h44, 10'h0, 4'd10, 2'd0, 1, 0, 0);
        chk("flush_cleared", 64'(flush_o), 64'd0);
        drain();
        chk("retired_after_jump", 64'(retired_o), 64'd5);
        // end with jump on the same slot: halt wins, later writes blocked
        slot(EN | WI | JMP | ENDF, 64'h0, 64'h99, 10'h155, 4'd4, 2'd0, 0, 0, 0);
        slot(EN | WI | WV, 64'h0, 64'hAA, 10'h0, 4'd6, 2'd3, 0, 0, 0);
        chk("halt_set", 64'(halt_o), 64'd1);
        chk("halt_no_pc_load", 64'(pc_load_o), 64'd0);
        slot(EN | WI, 64'h0, 64'hBB, 10'h0, 4'd1, 2'd0, 0, 0, 0);
        drain();
        chk("halt_sticky", 64'(halt_o), 64'd1);
        chk("retired_after_halt", 64'(retired_o), 64'd6);
        // reset leaves halt, then asynchronous reset mid-squash
        @(negedge clk_i);
        #2 rst_i = 1'b0;
        #1 chk("halt_cleared_by_reset", 64'(halt_o), 64'd0);
        @(posedge clk_i);
        #3 rst_i = 1'b1;
        slot(JMP, 64'h0, 64'h0, 10'h2A5, 4'd0, 2'd0, 0, 0, 1);
        idle();
        chk("flush_before_reset", 64'(flush_o), 64'd1);
        #2 rst_i = 1'b0;
        #1 chk_zero("async_reset");
        @(posedge clk_i);
        #3 rst_i = 1'b1;
        slot(EN | WI, 64'h0, 64'h77, 10'h0, 4'd2, 2'd0, 1, 0, 0);
        drain();
        chk("retired_after_reset", 64'(retired_o), 64'd1);
        // retire counter saturation
        @(negedge clk_i);
        #2 rst_i = 1'b0;
        @(posedge clk_i);
        #3 rst_i = 1'b1;
        repeat (65534) slot(EN, 64'h0, 64'h0, 10'h0, 4'd0, 2'd0, 0, 0, 0);
        idle();
        chk("retired_fffe", 64'(retired_o), 64'hFFFE);
        slot(EN, 64'h0, 64'h0, 10'h0, 4'd0, 2'd0, 0, 0, 0);
        idle();
        chk("retired_ffff", 64'(retired_o), 64'hFFFF);
        repeat (3) slot(EN, 64'h0, 64'h0, 10'h0, 4'd0, 2'd0, 0, 0, 0);
        idle();
        chk("retired_saturated", 64'(retired_o), 64'hFFFF);
        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/super_writeback.md
SUPER_WRITEBACK -- requirements
Module: super_writeback

Interface
REQ-001 The module SHALL have parameter REGI_BITS, default 4, meaning integer register address width.
REQ-002 The module SHALL have parameter VECT_BITS, default 2, meaning vector register address width.
REQ-003 The module SHALL have parameters VECT_SIZE, default 8, and ELEM_SIZE, default 8; data width DW = VECT_SIZE*ELEM_SIZE.
REQ-004 The module SHALL have parameter SQUASH_SLOTS, default 2, meaning younger in-flight instructions killed after a taken jump (range 1..7).
REQ-005 Ports SHALL be:
- clk_i  in  1  sole clock; rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- int_rd_i  in  DW  memory read data from the memory stage pipe.
- alu_res_i  in  DW  execute result carried alongside.
- enableReg_i, enableJump_i, flagMemRead_i, flagMemWrite_i, flagEnd_i, flagNop_i  in  1 each  stage control flags.
- writeResultInt_i, writeResultV_i  in  1 each  destination-file select.
- jumpAddress_i  in  10  jump target.
- intRegDest_i  in  REGI_BITS; vecRegDest_i  in  VECT_BITS  destination registers.
- int_we_o  out  1; int_wa_o  out  REGI_BITS; int_wd_o  out  DW  integer register-file write port.
- vec_we_o  out  1; vec_wa_o  out  VECT_BITS; vec_wd_o  out  DW  vector register-file write port.
- pc_load_o  out  1; pc_addr_o  out  10  fetch redirect.
- flush_o  out  1  high while squash window active.
- halt_o  out  1  sticky end-of-program.
- retired_o  out  16  retired-instruction count.

Function
REQ-006 All outputs SHALL be registered; an instruction presented at edge N produces its effects on outputs after edge N+1 (latency 1).
REQ-007 An input slot SHALL be valid when flagNop_i=0, state is RUN, and halt_o=0.
REQ-008 Write data SHALL be int_rd_i when flagMemRead_i=1, else alu_res_i; both int_wd_o and vec_wd_o carry it.
REQ-009 int_we_o SHALL be 1 for one cycle iff valid, enableReg_i=1, writeResultInt_i=1, flagMemWrite_i=0; int_wa_o=intRegDest_i.
REQ-010 vec_we_o SHALL follow the same rule with writeResultV_i and vec_wa_o=vecRegDest_i; both write enables may assert together.
REQ-011 The FSM SHALL have states RUN, SQUASH, HALT; reset state RUN.
REQ-012 RUN, valid, enableJump_i=1, flagEnd_i=0: pc_load_o=1 for one cycle, pc_addr_o=jumpAddress_i, go to SQUASH with squash counter=SQUASH_SLOTS; the jumping instruction still writes back per REQ-009/010.
REQ-013 SQUASH: every arriving slot (nop or not) SHALL decrement the counter and produce no writes, no pc_load, no retire; at counter reaching 0 return to RUN; flush_o=1 throughout SQUASH.
REQ-014 Valid flagEnd_i=1: go to HALT, halt_o=1 sticky; the end instruction itself produces no write and retires; enableJump_i on the same slot SHALL be ignored (end wins).
REQ-015 HALT SHALL be left only via reset; all write enables and pc_load_o stay 0.
REQ-016 retired_o SHALL increment by 1 per valid slot and saturate at 16'hFFFF.
REQ-017 pc_addr_o, int_wa_o, vec_wa_o, data outputs SHALL hold their last values when enables are 0.

Reset
REQ-018 rst_i=0 SHALL immediately force state RUN, squash counter 0, and all outputs 0, independent of clk_i.
REQ-019 Reset asserted mid-SQUASH or in HALT SHALL abandon the window/halt; first valid slot after release is processed normally.

Verification
REQ-020 Load: flagMemRead_i=1, int_rd_i=64'h0123456789ABCDEF, alu_res_i=0, intRegDest_i=5, enableReg_i=1, writeResultInt_i=1 -> next cycle int_we_o=1, int_wa_o=5, int_wd_o=64'h0123456789ABCDEF.
REQ-021 Jump to 10'h3A0 followed by three ALU int writes -> pc_load_o=1, pc_addr_o=10'h3A0 one cycle; flush_o=1 two cycles; first two writes suppressed, third writes.
REQ-022 Slot with flagEnd_i=1 and enableJump_i=1 -> halt_o=1, pc_load_o=0; later valid writes produce no int_we_o/vec_we_o.
REQ-023 Store (flagMemWrite_i=1, enableReg_i=1, writeResultV_i=1) -> vec_we_o=0, retired_o +1; nop slot -> retired_o unchanged.
REQ-024 Preload retired_o near 16'hFFFF via 65535 valid slots, then 3 more -> retired_o stays 16'hFFFF.
REQ-025 rst_i low between clock edges during SQUASH -> all outputs 0 at once, flush_o=0; next write after release is not squashed.
